// File: rtl/id_stage.sv
// id_stage: RV32I decode stage holding the IF/ID and ID/EX pipeline registers,
// with a load-use bubble, same-cycle writeback bypass and redirect squash.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] readData1,
  input  logic [XLEN-1:0] readData2,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
    logic            jump;
    logic            illegal;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    ctl_t            ctl;
  } id_ex_t;

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            ex_valid_q, ex_valid_d;
  id_ex_t          ex_q, ex_d, ex_new;

  ctl_t            ctl;
  logic            uses_rs1, uses_rs2;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7b5;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] op1, op2;
  logic            hazard, ex_accept, id_advance;

  assign opcode = id_instr_q[6:0];
  assign funct3 = id_instr_q[14:12];
  assign f7b5   = id_instr_q[30];

  assign imm_i = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
  assign imm_s = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
  assign imm_b = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
                  id_instr_q[30:25], id_instr_q[11:8], 1'b0};
  assign imm_u = {id_instr_q[31:12], 12'b0};
  assign imm_j = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12],
                  id_instr_q[20], id_instr_q[30:21], 1'b0};

  always_comb begin
    ctl         = '0;
    ctl.rd      = id_instr_q[11:7];
    ctl.funct3  = funct3;
    ctl.alu_src = 1'b1;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        uses_rs1      = 1'b0;
        ctl.imm       = imm_u;
        ctl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        uses_rs1      = 1'b0;
        ctl.imm       = imm_j;
        ctl.reg_write = 1'b1;
        ctl.jump      = 1'b1;
      end
      OPC_JALR: begin
        ctl.imm       = imm_i;
        ctl.reg_write = 1'b1;
        ctl.jump      = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs2    = 1'b1;
        ctl.imm     = imm_b;
        ctl.rd      = 5'd0;
        ctl.alu_op  = 4'b1000;
        ctl.alu_src = 1'b0;
        ctl.branch  = 1'b1;
      end
      OPC_LOAD: begin
        ctl.imm        = imm_i;
        ctl.reg_write  = 1'b1;
        ctl.mem_read   = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        uses_rs2      = 1'b1;
        ctl.imm       = imm_s;
        ctl.rd        = 5'd0;
        ctl.mem_write = 1'b1;
      end
      OPC_OPIMM: begin
        ctl.imm       = imm_i;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = {(funct3 == 3'b101) & f7b5, funct3};
      end
      OPC_OP: begin
        uses_rs2      = 1'b1;
        ctl.alu_src   = 1'b0;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = {f7b5, funct3};
      end
      default: ctl.illegal = 1'b1;
    endcase
  end

  assign rs1 = uses_rs1 ? id_instr_q[19:15] : 5'd0;
  assign rs2 = uses_rs2 ? id_instr_q[24:20] : 5'd0;

  // The register file writes at the edge, so a value being written this cycle
  // is not yet visible on readData and must be taken from the WB port.
  assign op1 = (rs1 == 5'd0) ? '0 :
               (wb_reg_write && wb_rd == rs1) ? wb_data : readData1;
  assign op2 = (rs2 == 5'd0) ? '0 :
               (wb_reg_write && wb_rd == rs2) ? wb_data : readData2;

  assign ex_new = {id_pc_q, op1, op2, rs1, rs2, ctl};

  assign hazard = id_valid_q & ex_valid_q & ex_q.ctl.mem_read & (ex_q.ctl.rd != 5'd0) &
                  ((uses_rs1 & (ex_q.ctl.rd == rs1)) | (uses_rs2 & (ex_q.ctl.rd == rs2)));
  assign ex_accept  = ~ex_valid_q | ex_ready;
  assign id_advance = id_valid_q & ex_accept & ~hazard;
  assign if_ready   = ~flush & (~id_valid_q | id_advance);

  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end else begin
      if (if_ready) begin
        id_valid_d = if_valid;
        if (if_valid) begin
          id_instr_d = if_instr;
          id_pc_d    = if_pc;
        end
      end
      if (ex_accept) begin
        ex_valid_d = id_valid_q & ~hazard;
        if (id_advance) ex_d = ex_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_imm        = ex_q.ctl.imm;
  assign ex_rd         = ex_q.ctl.rd;
  assign ex_funct3     = ex_q.ctl.funct3;
  assign ex_alu_op     = ex_q.ctl.alu_op;
  assign ex_alu_src    = ex_q.ctl.alu_src;
  assign ex_mem_read   = ex_q.ctl.mem_read;
  assign ex_mem_write  = ex_q.ctl.mem_write;
  assign ex_reg_write  = ex_q.ctl.reg_write;
  assign ex_mem_to_reg = ex_q.ctl.mem_to_reg;
  assign ex_branch     = ex_q.ctl.branch;
  assign ex_jump       = ex_q.ctl.jump;
  assign ex_illegal    = ex_q.ctl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against an
// in-order instruction scoreboard fed by a behavioural RV32I decode model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0, if_ready;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic        flush = 1'b0;
  logic [4:0]  rs1, rs2;
  logic [31:0] readData1, readData2;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_valid, ex_ready = 1'b1;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch, ex_jump, ex_illegal;

  logic [31:0] rf [32];
  assign readData1 = rf[rs1];
  assign readData2 = rf[rs2];

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .rs1(rs1), .rs2(rs2),
    .readData1(readData1), .readData2(readData2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  r1, r2, rd;
    logic [2:0]  f3;
    logic [3:0]  aop;
    logic [7:0]  ctl;
    bit          imm_known;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          sb_en = 1'b0;
  exp_t        sbq[$];
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Decode rules written directly from the ISA field layout using integer arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int s, sgn, op, f3, rdv, r1v, r2v, f7b5, imm;
    bit legal, uses1, uses2;
    s    = int'(ins);
    sgn  = s >>> 31;
    op   = int'(ins & 32'h7F);
    f3   = int'((ins >> 12) & 32'h7);
    rdv  = int'((ins >> 7) & 32'h1F);
    r1v  = int'((ins >> 15) & 32'h1F);
    r2v  = int'((ins >> 20) & 32'h1F);
    f7b5 = int'((ins >> 30) & 32'h1);
    legal = (op == 'h37) || (op == 'h17) || (op == 'h6F) || (op == 'h67) || (op == 'h63) ||
            (op == 'h03) || (op == 'h23) || (op == 'h13) || (op == 'h33);
    uses1 = !((op == 'h37) || (op == 'h17) || (op == 'h6F));
    uses2 = (op == 'h63) || (op == 'h23) || (op == 'h33);
    imm = 0;
    if (op == 'h37 || op == 'h17) imm = int'(ins & 32'hFFFF_F000);
    else if (op == 'h6F) imm = sgn * 1048576 + int'((ins >> 12) & 32'hFF) * 4096 +
                              int'((ins >> 20) & 32'h1) * 2048 + int'((ins >> 21) & 32'h3FF) * 2;
    else if (op == 'h63) imm = sgn * 4096 + int'((ins >> 7) & 32'h1) * 2048 +
                              int'((ins >> 25) & 32'h3F) * 32 + int'((ins >> 8) & 32'hF) * 2;
    else if (op == 'h23) imm = (s >>> 25) * 32 + rdv;
    else if (op == 'h67 || op == 'h03 || op == 'h13) imm = s >>> 20;
    e.pc  = pc;
    e.imm = 32'(imm);
    e.imm_known = legal && (op != 'h33);
    e.r1  = uses1 ? 5'(r1v) : 5'd0;
    e.r2  = uses2 ? 5'(r2v) : 5'd0;
    e.d1  = (e.r1 == 5'd0) ? 32'd0 : rf[e.r1];
    e.d2  = (e.r2 == 5'd0) ? 32'd0 : rf[e.r2];
    e.rd  = (op == 'h63 || op == 'h23) ? 5'd0 : 5'(rdv);
    e.f3  = 3'(f3);
    if (op == 'h33)      e.aop = 4'(f7b5 * 8 + f3);
    else if (op == 'h13) e.aop = 4'(((f3 == 5) ? f7b5 : 0) * 8 + f3);
    else if (op == 'h63) e.aop = 4'd8;
    else                 e.aop = 4'd0;
    e.ctl = {!(op == 'h33 || op == 'h63), op == 'h03, op == 'h23,
             legal && !(op == 'h63 || op == 'h23), op == 'h03, op == 'h63,
             op == 'h6F || op == 'h67, !legal};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr(input bit allow_load);
    logic [31:0] ins;
    int k;
    k   = $urandom_range(0, 9);
    ins = $urandom();
    if (!allow_load && k == 5) k = 8;
    case (k)
      0: ins[6:0] = 7'h37;
      1: ins[6:0] = 7'h17;
      2: ins[6:0] = 7'h6F;
      3: ins[6:0] = 7'h67;
      4: ins[6:0] = 7'h63;
      5: ins[6:0] = 7'h03;
      6: ins[6:0] = 7'h23;
      7: ins[6:0] = 7'h13;
      8: ins[6:0] = 7'h33;
      default: ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h73;
    endcase
    return ins;
  endfunction

  always @(negedge clk) begin
    if (reset && sb_en) begin
      if (flush) sbq.delete();
      else begin
        if (ex_valid && ex_ready) begin
          checkOutput("sb_expected_pending", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput("sb_pc", ex_pc, e.pc);
            checkOutput("sb_rs1_data", ex_rs1_data, e.d1);
            checkOutput("sb_rs2_data", ex_rs2_data, e.d2);
            if (e.imm_known) checkOutput("sb_imm", ex_imm, e.imm);
            checkOutput("sb_regs", 32'({ex_rs1, ex_rs2, ex_rd}), 32'({e.r1, e.r2, e.rd}));
            checkOutput("sb_funct3_aluop", 32'({ex_funct3, ex_alu_op}), 32'({e.f3, e.aop}));
            checkOutput("sb_ctl", 32'({ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                                       ex_mem_to_reg, ex_branch, ex_jump, ex_illegal}), 32'(e.ctl));
          end
        end
        if (if_valid && if_ready) sbq.push_back(model(if_instr, if_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic er, input logic fl);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    ex_ready = er;
    flush    = fl;
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    applyStimulus(1'b1, ins, pc_ctr, 1'b1, 1'b0);
    pc_ctr += 4;
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic drain();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && (sbq.size() != 0 || ex_valid); i++) tick();
    repeat (2) tick();
    if (sb_en) checkOutput("drain_queue_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    bit          tp_exp [6];
    logic [31:0] i1, i2, i3, p1;
    exp_t        m1;
    tp_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
    rf[0] = 32'hDEAD_0001;

    #12;
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_if_ready", 32'(if_ready), 32'd1);
    checkOutput("rst_ex_pc", ex_pc, 32'd0);
    checkOutput("rst_ex_imm", ex_imm, 32'd0);
    checkOutput("rst_ex_rd", 32'(ex_rd), 32'd0);
    checkOutput("rst_ctl", 32'({ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                                ex_mem_to_reg, ex_branch, ex_jump, ex_illegal}), 32'd0);
    tick();
    reset = 1'b1;
    sb_en = 1'b1;

    applyStimulus(1'b1, 32'h0070_0293, pc_ctr, 1'b1, 1'b0);
    pc_ctr += 4;
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("lat_ex_valid_c1", 32'(ex_valid), 32'd0);
    tick();
    checkOutput("lat_ex_valid_c2", 32'(ex_valid), 32'd1);
    checkOutput("addi_rd", 32'(ex_rd), 32'd5);
    checkOutput("addi_imm", ex_imm, 32'd7);
    checkOutput("addi_src_wr", 32'({ex_alu_src, ex_reg_write}), 32'd3);
    tick();
    checkOutput("addi_single", 32'(ex_valid), 32'd0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(k < 4, rand_instr(1'b0), pc_ctr, 1'b1, 1'b0);
      pc_ctr += 4;
      checkOutput("tp_if_ready", 32'(if_ready), 32'd1);
      tick();
      checkOutput("tp_ex_valid", 32'(ex_valid), 32'(tp_exp[k]));
    end
    drain();

    // lw x6,0(x5) then add x7,x6,x6: one bubble
    applyStimulus(1'b1, 32'h0002_A303, pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, 32'h0063_03B3, pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("lu_if_ready_stall", 32'(if_ready), 32'd0);
    checkOutput("lu_ex_valid_load", 32'(ex_valid), 32'd1);
    tick();
    checkOutput("lu_bubble", 32'(ex_valid), 32'd0);
    checkOutput("lu_if_ready_release", 32'(if_ready), 32'd1);
    tick();
    checkOutput("lu_dep_valid", 32'(ex_valid), 32'd1);
    checkOutput("lu_dep_rd", 32'(ex_rd), 32'd7);
    drain();

    // lw x6,0(x5) then add x7,x0,x0: no bubble
    applyStimulus(1'b1, 32'h0002_A303, pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, 32'h0000_03B3, pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("nolu_if_ready", 32'(if_ready), 32'd1);
    tick();
    checkOutput("nolu_ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("nolu_rd", 32'(ex_rd), 32'd7);
    drain();

    sb_en = 1'b0;
    sbq.delete();
    rf[10] = 32'd0;
    wb_reg_write = 1'b1;
    wb_rd = 5'd10;
    wb_data = 32'hABCD_EF12;
    issue(32'h0005_00B3);
    checkOutput("byp_rs1", ex_rs1_data, 32'hABCD_EF12);
    issue(32'h00A0_00B3);
    checkOutput("byp_rs2", ex_rs2_data, 32'hABCD_EF12);
    checkOutput("byp_x0_rs1", ex_rs1_data, 32'd0);
    wb_rd = 5'd0;
    issue(32'h0005_00B3);
    checkOutput("byp_wb_x0", ex_rs1_data, 32'd0);
    wb_reg_write = 1'b0;
    drain();

    sb_en = 1'b1;
    i1 = rand_instr(1'b0); i2 = rand_instr(1'b0); i3 = rand_instr(1'b0);
    p1 = pc_ctr;
    m1 = model(i1, p1);
    applyStimulus(1'b1, i1, pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, i2, pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, i3, pc_ctr, 1'b0, 1'b0);
    checkOutput("bp_if_ready_drop", 32'(if_ready), 32'd0);
    repeat (3) begin
      tick();
      checkOutput("bp_hold_valid", 32'(ex_valid), 32'd1);
      checkOutput("bp_hold_pc", ex_pc, p1);
      checkOutput("bp_hold_rd", 32'(ex_rd), 32'(m1.rd));
      checkOutput("bp_if_ready", 32'(if_ready), 32'd0);
    end
    applyStimulus(1'b1, i3, pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    checkOutput("bp_release_ready", 32'(if_ready), 32'd1);
    tick();
    drain();

    sb_en = 1'b0;
    sbq.delete();
    applyStimulus(1'b1, rand_instr(1'b0), pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, rand_instr(1'b0), pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, rand_instr(1'b0), pc_ctr, 1'b1, 1'b1); pc_ctr += 4;
    checkOutput("fl_if_ready", 32'(if_ready), 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("fl_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("fl_if_ready_after", 32'(if_ready), 32'd1);
    tick();
    checkOutput("fl_id_squashed", 32'(ex_valid), 32'd0);

    sb_en = 1'b1;
    issue(32'hFE20_8CE3);
    checkOutput("beq_imm", ex_imm, 32'hFFFF_FFF8);
    checkOutput("beq_rd", 32'(ex_rd), 32'd0);
    checkOutput("beq_branch", 32'(ex_branch), 32'd1);
    issue(32'h0010_00EF);
    checkOutput("jal_imm", ex_imm, 32'h0000_0800);
    issue(32'h0000_007F);
    checkOutput("ill_illegal", 32'(ex_illegal), 32'd1);
    checkOutput("ill_reg_write", 32'(ex_reg_write), 32'd0);
    drain();

    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, rand_instr(1'b1), pc_ctr,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      pc_ctr += 4;
      tick();
    end
    drain();

    sb_en = 1'b0;
    sbq.delete();
    applyStimulus(1'b1, rand_instr(1'b0), pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, rand_instr(1'b0), pc_ctr, 1'b1, 1'b0); pc_ctr += 4;
    tick();
    applyStimulus(1'b1, rand_instr(1'b0), pc_ctr, 1'b0, 1'b0);
    tick();
    checkOutput("stall_before_reset", 32'(ex_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("async_rst_if_ready", 32'(if_ready), 32'd1);
    @(negedge clk) reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

RV32I instruction-decode pipeline stage sitting directly upstream of `Reg_File`. Holds the IF/ID pipeline register, decodes the instruction, drives the register file read addresses and captures the returned operands, immediate and control bundle into the ID/EX register. Inserts a load-use bubble, bypasses a same-cycle writeback and squashes on branch/jump redirect. The fetch and execute sides use valid/ready handshakes.

## Interface
- `XLEN`, 32, data/PC width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all pipeline state.
- `if_valid` / `if_ready`  in / out  1  fetch handshake; a transfer occurs when both are high at a clock edge.
- `if_instr`, `if_pc`  in  32  fetched instruction and its PC.
- `flush`  in  1  redirect from EX; squashes IF/ID and ID/EX.
- `rs1`, `rs2`  out  5  register file read addresses; combinational from IF/ID.
- `readData1`, `readData2`  in  32  register file read data; combinational.
- `wb_reg_write`, `wb_rd`, `wb_data`  in  1/5/32  writeback port being written into `Reg_File` this cycle.
- `ex_valid` / `ex_ready`  out / in  1  execute handshake.
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  32  ID/EX payload.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5  register indices, used by forwarding.
- `ex_funct3`  out  3; `ex_alu_op`  out  4; `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg`, `ex_branch`, `ex_jump`, `ex_illegal`  out  1  control bundle.

## Operation
- **Decoded opcodes:** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - Any other opcode sets `ex_illegal=1`, forces `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` and `ex_jump` to 0, and still passes down as valid.
- **Immediates:** I, S, B, U and J formats, sign-extended to 32 bits.
  - U: `{instr[31:12], 12'b0}`.
  - B and J: bit 0 is 0.
- **Register usage:**
  - `uses_rs1` is 0 for LUI, AUIPC and JAL.
  - `uses_rs2` is 1 only for BRANCH, STORE and OP.
  - An unused `rs1`/`rs2` is driven as 0.
  - `ex_rd` is 0 for BRANCH and STORE.
- **ALU op:**
  - OP: `{funct7[5], funct3}`.
  - OP-IMM: `{funct3==3'b101 & funct7[5], funct3}`.
  - BRANCH: 4'b1000.
  - All others: 4'b0000 (add).
  - `ex_alu_src` is 1 for everything except OP and BRANCH.
- **Writeback bypass:** if `wb_reg_write && wb_rd!=0 && wb_rd==rs1`, operand 1 takes `wb_data` instead of `readData1`. Same rule for `rs2` and operand 2.
- **Register x0:** an operand read from x0 is always 0.
- **Control terms:**
  - `hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2))`.
  - `ex_accept = ~ex_valid | ex_ready`.
  - `id_advance = id_valid & ex_accept & ~hazard`.
  - `if_ready = ~flush & (~id_valid | id_advance)`.
- **IF/ID register update:**
  - On `flush`, `id_valid` goes to 0.
  - Else, if `if_ready`, `id_valid` takes `if_valid`; instr and pc are captured when `if_valid`.
  - Otherwise hold.
- **ID/EX register update:**
  - On `flush`, `ex_valid` goes to 0.
  - Else, if `ex_accept`, `ex_valid` takes `id_valid & ~hazard`; the payload loads only on `id_advance`.
  - Otherwise hold. Payload is stable while `ex_valid & ~ex_ready`.
- **Simultaneous events:** `flush` wins over every other event. A fetch handshake in the flush cycle is impossible, because `if_ready` is 0.

## Timing
- **Reset values:** `id_valid`=0 and `ex_valid`=0. Every `ex_*` payload and control output is 0. `if_ready`=1 once `flush` is low. Reset takes effect immediately, even mid-stall.
- **Latency:** 2 cycles, fetch transfer to `ex_valid`. With `ex_ready` held high, throughput is 1 instruction per cycle.
- **Load-use:** exactly one bubble when `ex_ready`=1. The dependent instruction holds in IF/ID and advances on the next cycle.
- **Backpressure:** `ex_ready`=0 freezes both registers once full. `if_ready` drops in the same cycle.
- **Operand sampling:** `readData*` is sampled on the cycle the payload loads. The WB bypass covers the register file's write-at-edge behaviour.

## Test plan
- **Reset and throughput:** after reset, feed `addi x5,x0,7` (0x00700293) with `ex_ready`=1 → two cycles later `ex_valid`=1, `ex_rd`=5, `ex_imm`=7, `ex_alu_src`=1, `ex_reg_write`=1. Then feed 4 back-to-back instructions → 4 consecutive `ex_valid` cycles.
- **Load-use bubble:** `lw x6,0(x5)` followed by `add x7,x6,x6` → one `ex_valid`=0 cycle between them and `if_ready`=0 for one cycle. Repeating with `add x7,x0,x0` → no bubble.
- **Writeback bypass:** `wb_reg_write`=1, `wb_rd`=10, `wb_data`=0xABCDEF12 while ID holds `add x1,x10,x0` with `readData1`=0 → `ex_rs1_data`=0xABCDEF12. With `wb_rd`=0 → `ex_rs1_data`=0.
- **Backpressure:** `ex_ready`=0 for 3 cycles with both stages full → `ex_*` is stable, `if_ready`=0, and no instruction is lost or duplicated after release.
- **Flush:** `flush`=1 with both stages valid → next cycle `ex_valid`=0, `id_valid`=0, and `if_ready` is 0 during the flush cycle.
- **Immediates and illegal:** `beq x1,x2,-8` → `ex_imm`=0xFFFFFFF8, `ex_rd`=0, `ex_branch`=1. `jal x1,2048` → `ex_imm`=0x00000800. Opcode 0x7F → `ex_illegal`=1 and `ex_reg_write`=0.
